uart_data_receiver: RTL and testbench

UART_DATA_RECEIVER -- requirements
Module: uart_data_receiver

---
 rtl/uart_data_receiver_if.sv | 12 +
 rtl/uart_data_receiver.sv | 97 +++++++++
 tb/tb_uart_data_receiver.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/uart_data_receiver_if.sv
// uart_data_receiver_if: serial line, baud select and received-word outputs of the UART word receiver
interface uart_data_receiver_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  uart_rx;
  logic [2:0]            baud_set;
  logic [DATA_WIDTH-1:0] data;
  logic                  rx_done;
  logic                  timeout_flag;
  modport master (output uart_rx, baud_set, input data, rx_done, timeout_flag);
  modport slave (input uart_rx, baud_set, output data, rx_done, timeout_flag);
endinterface

// File: rtl/uart_data_receiver.sv
// uart_data_receiver: 8N1 UART receiver assembling bytes into DATA_WIDTH words with an idle timeout
module uart_data_receiver #(
  parameter int DATA_WIDTH = 32,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                clk,
  input  logic                nrst,
  uart_data_receiver_if.slave bus
);
  localparam int NB  = DATA_WIDTH / 8;
  localparam int BCW = NB > 1 ? $clog2(NB) : 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t                state, nxt;
  logic                  s1, s2, rx_prev, frame_err;
  logic [12:0]           baud_cnt, period, lim;
  logic [16:0]           to_cnt;
  logic [2:0]            bit_cnt;
  logic [7:0]            rx_byte;
  logic [BCW-1:0]        byte_cnt;
  logic [DATA_WIDTH-1:0] word, next_word;
  logic                  start_edge, hit, accept, ferr_hit, last, to_run, to_hit;
  always_comb begin
    case (bus.baud_set)
      3'd0: period = 13'd5208;
      3'd1: period = 13'd2604;
      3'd2: period = 13'd1302;
      3'd3: period = 13'd868;
      3'd4: period = 13'd434;
      3'd5: period = 13'd217;
      3'd6: period = 13'd109;
      3'd7: period = 13'd54;
    endcase
  end
  // START waits half a bit to land on the start-bit centre; later bits are a full period apart
  assign lim        = state == START ? {1'b0, period[12:1]} - 13'd1 : period - 13'd1;
  assign start_edge = rx_prev & ~s2;
  assign hit        = baud_cnt == lim && !frame_err;
  assign accept     = state == STOP && hit && s2;
  assign ferr_hit   = state == STOP && hit && !s2;
  assign last       = byte_cnt == BCW'(NB - 1);
  assign to_run     = state == IDLE && byte_cnt != '0 && !start_edge;
  assign to_hit     = to_cnt == {period, 4'd0} - 17'd1;
  assign next_word  = MSB_FIRST ? DATA_WIDTH'({word, rx_byte}) : DATA_WIDTH'({rx_byte, word} >> 8);
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  nxt = start_edge ? START : IDLE;
      START: nxt = hit ? (s2 ? IDLE : DATA) : START;
      DATA:  nxt = hit && bit_cnt == 3'd7 ? STOP : DATA;
      STOP:  nxt = accept || (frame_err && s2) ? IDLE : STOP;
    endcase
  end
  always_ff @(posedge clk) begin
    if (nrst) begin
      state            <= IDLE;
      s1               <= 1'b1;
      s2               <= 1'b1;
      rx_prev          <= 1'b1;
      frame_err        <= 1'b0;
      baud_cnt         <= '0;
      bit_cnt          <= '0;
      rx_byte          <= '0;
      byte_cnt         <= '0;
      to_cnt           <= '0;
      word             <= '0;
      bus.data         <= '0;
      bus.rx_done      <= 1'b0;
      bus.timeout_flag <= 1'b0;
    end else begin
      state            <= nxt;
      s1               <= bus.uart_rx;
      s2               <= s1;
      rx_prev          <= s2;
      bus.rx_done      <= 1'b0;
      bus.timeout_flag <= 1'b0;
      baud_cnt         <= (state == IDLE || hit || frame_err) ? '0 : baud_cnt + 13'd1;
      bit_cnt          <= state != DATA ? '0 : hit ? bit_cnt + 3'd1 : bit_cnt;
      if (state == DATA && hit)
        rx_byte <= {s2, rx_byte[7:1]};
      // a framing error parks in STOP until the line returns high
      frame_err <= ferr_hit || (frame_err && !s2);
      to_cnt    <= to_run && !to_hit ? to_cnt + 17'd1 : '0;
      if (accept) begin
        byte_cnt <= last ? '0 : byte_cnt + BCW'(1);
        word     <= last ? '0 : next_word;
        if (last) begin
          bus.data    <= next_word;
          bus.rx_done <= 1'b1;
        end
      end else if (ferr_hit || (to_run && to_hit)) begin
        byte_cnt         <= '0;
        word             <= '0;
        bus.timeout_flag <= to_run && to_hit;
      end
    end
  end
endmodule

// File: tb/tb_uart_data_receiver.sv
// tb_uart_data_receiver: LSB-first and MSB-first receivers on one serial line, scoreboard-checked
module tb_uart_data_receiver;
  logic clk = 1'b0;
  logic nrst = 1'b1;
  logic line = 1'b1;
  logic [2:0] baud = 3'd4;
  always #10 clk = ~clk;
  uart_data_receiver_if #(.DATA_WIDTH(32)) bl ();
  uart_data_receiver_if #(.DATA_WIDTH(32)) bm ();
  assign bl.uart_rx  = line;
  assign bl.baud_set = baud;
  assign bm.uart_rx  = line;
  assign bm.baud_set = baud;
  uart_data_receiver #(.DATA_WIDTH(32), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .nrst(nrst), .bus(bl.slave));
  uart_data_receiver #(.DATA_WIDTH(32), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .nrst(nrst), .bus(bm.slave));
  typedef struct {
    bit          is_to;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t q_l[$];
  exp_t q_m[$];
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int stop_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic int period(input logic [2:0] b);
    case (b)
      3'd0: return 5208;
      3'd1: return 2604;
      3'd2: return 1302;
      3'd3: return 868;
      3'd4: return 434;
      3'd5: return 217;
      3'd6: return 109;
      default: return 54;
    endcase
  endfunction
  task automatic idle(input int n);
    line = 1'b1;
    repeat (n) @(negedge clk);
  endtask
  task automatic tx_bit(input logic v);
    line = v;
    repeat (period(baud)) @(negedge clk);
  endtask
  task automatic tx_byte(input logic [7:0] b, input logic stop_ok);
    tx_bit(1'b0);
    for (int i = 0; i < 8; i++) tx_bit(b[i]);
    stop_cyc = cyc;
    tx_bit(stop_ok);
    if (!stop_ok) tx_bit(1'b1);
  endtask
  task automatic push(input bit to, input logic [31:0] dl, input logic [31:0] dm, input int c);
    q_l.push_back('{to, dl, c});
    q_m.push_back('{to, dm, c});
  endtask
  // bytes go out w[7:0] first; wm is the hand-computed word for the MSB-first receiver
  task automatic send_word(input logic [31:0] w, input logic [31:0] wm);
    push(1'b0, w, wm, 0);
    for (int i = 0; i < 4; i++) tx_byte(w[8*i +: 8], 1'b1);
  endtask
  task automatic check_zero(input string name);
    n_chk++;
    if (bl.data !== 32'h0 || bl.rx_done !== 1'b0 || bl.timeout_flag !== 1'b0 ||
        bm.data !== 32'h0 || bm.rx_done !== 1'b0 || bm.timeout_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: data=%h/%h rx_done=%b/%b timeout_flag=%b/%b, required all zero", name,
               bl.data, bm.data, bl.rx_done, bm.rx_done, bl.timeout_flag, bm.timeout_flag);
    end
  endtask
  task automatic check(input int which, input logic done, input logic to, input logic [31:0] d);
    exp_t e;
    if (!(done || to)) return;
    n_chk++;
    if (done && to) begin
      n_fail++;
      $display("FAIL both_pulses dut%0d: rx_done=1 timeout_flag=1 at cycle %0d, required never together", which, cyc);
      return;
    end
    if ((which == 0 ? q_l.size() : q_m.size()) == 0) begin
      n_fail++;
      $display("FAIL unexpected_event dut%0d: rx_done=%b timeout_flag=%b data=%h at cycle %0d, required no event",
               which, done, to, d, cyc);
      return;
    end
    if (which == 0) e = q_l.pop_front();
    else e = q_m.pop_front();
    if (e.is_to != to || d !== e.data || (e.is_to && (cyc < e.cyc - 2 || cyc > e.cyc + 2))) begin
      n_fail++;
      $display("FAIL event dut%0d: timeout=%b data=%h cycle=%0d, required timeout=%b data=%h cycle=%0d",
               which, to, d, cyc, e.is_to, e.data, e.is_to ? e.cyc : cyc);
    end
  endtask
  always @(negedge clk) begin
    if (!nrst) begin
      check(0, bl.rx_done, bl.timeout_flag, bl.data);
      check(1, bm.rx_done, bm.timeout_flag, bm.data);
    end
  end
  initial begin
    repeat (98000) @(posedge clk);
    $display("FAIL watchdog: cycle=%0d, required finish before 98000", cyc);
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog expired");
  end
  initial begin
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    nrst = 1'b0;
    idle(20);
    send_word(32'h12345678, 32'h78563412);
    idle(600);
    send_word(32'h87654321, 32'h21436587);
    idle(600);
    send_word(32'h24680135, 32'h35016824);
    idle(600);
    line = 1'b0;
    repeat (100) @(negedge clk);
    idle(5000);
    baud = 3'd7;
    idle(50);
    send_word(32'hDEADBEEF, 32'hEFBEADDE);
    idle(100);
    send_word(32'h78563412, 32'h12345678);
    idle(100);
    // timeout lands 16 bit periods after the stop-bit centre plus the 3-cycle sync/edge delay
    tx_byte(8'hAA, 1'b1);
    tx_byte(8'h55, 1'b1);
    push(1'b1, 32'h78563412, 32'h12345678, stop_cyc + 27 + 3 + 16 * 54);
    idle(20 * 54);
    send_word(32'hCAFEF00D, 32'h0DF0FECA);
    idle(100);
    tx_byte(8'h11, 1'b1);
    tx_byte(8'h22, 1'b1);
    tx_byte(8'h33, 1'b0);
    idle(20 * 54);
    send_word(32'h0BADC0DE, 32'hDEC0AD0B);
    idle(100);
    tx_byte(8'h5A, 1'b1);
    tx_bit(1'b0);
    tx_bit(1'b1);
    tx_bit(1'b0);
    line = 1'b1;
    nrst = 1'b1;
    @(negedge clk);
    check_zero("mid_frame_reset");
    nrst = 1'b0;
    idle(20 * 54);
    send_word(32'h13579BDF, 32'hDF9B5713);
    for (int i = 0; i < 2000 && (q_l.size() + q_m.size()) > 0; i++) @(negedge clk);
    n_chk++;
    if (q_l.size() + q_m.size() > 0) begin
      n_fail++;
      $display("FAIL drain: pending events=%0d/%0d, required 0/0", q_l.size(), q_m.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
